// File: rtl/mux2_8_arb_pkg.sv
// mux2_8_arb_pkg: shared definitions for the mux2_8_arb arbiter slice.
//   state_e           : arbiter state encoding (IDLE / OWN_A / OWN_B)
//   SEL_A / SEL_B     : mux select values; also used to record the last served source
//   MAX_BURST_DEFAULT : default burst bound per grant while the other source waits
package mux2_8_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int unsigned MAX_BURST_DEFAULT = 4;

  // Select value that corresponds to an owning state; IDLE has no owner.
  function automatic logic owner_sel(input state_e st);
    return (st == OWN_B) ? SEL_B : SEL_A;
  endfunction

endpackage

// File: rtl/mux2_8_arb_mux.sv
// mux2_8: 8-bit 2:1 data select.
//   a_i   : data presented when sel_i = 0
//   b_i   : data presented when sel_i = 1
//   sel_i : select
//   y_o   : selected data (combinational)
module mux2_8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       sel_i,
  output logic [7:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux2_8_arb.sv
// mux2_8_arb: two-source round-robin arbiter with bounded bursts feeding one
// registered valid/ready output channel through the mux2_8 data select.
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   a_data/a_valid/a_ready: source A beat handshake
//   b_data/b_valid/b_ready: source B beat handshake
//   mux_sel               : registered select, 0 = A, 1 = B (holds in IDLE)
//   out_data/out_src      : registered beat and the source it came from
//   out_valid/out_ready   : output handshake
//   stat_a/stat_b         : saturating accepted-beat counters, present only when
//                           MUX2_8_ARB_STATS_EN is defined
module mux2_8_arb
  import mux2_8_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  a_data,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [7:0]  b_data,
  input  logic        b_valid,
  output logic        b_ready,
  output logic        mux_sel,
  output logic [7:0]  out_data,
  output logic        out_src,
  output logic        out_valid,
`ifdef MUX2_8_ARB_STATS_EN
  output logic [15:0] stat_a,
  output logic [15:0] stat_b,
`endif
  input  logic        out_ready
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          mux_sel_q, mux_sel_d;
  logic [7:0]    out_data_q;
  logic          out_src_q;
  logic          out_valid_q;

  logic [7:0]    mux_y;
  logic          acc_a, acc_b;
  logic          own_valid, oth_valid, own_acc;
  logic [CW:0]   cnt_inc;
  state_e        other_st;

  mux2_8 u_mux (
    .a_i   (a_data),
    .b_i   (b_data),
    .sel_i (mux_sel_q),
    .y_o   (mux_y)
  );

  // mux_sel_q always matches the owning state, so the mux already presents
  // the owner's beat in any cycle where that owner can be accepted.
  always_comb begin
    a_ready   = (state_q == OWN_A) && (!out_valid_q || out_ready);
    b_ready   = (state_q == OWN_B) && (!out_valid_q || out_ready);
    acc_a     = a_valid && a_ready;
    acc_b     = b_valid && b_ready;

    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    mux_sel_d = mux_sel_q;

    own_valid = (state_q == OWN_B) ? b_valid : a_valid;
    oth_valid = (state_q == OWN_B) ? a_valid : b_valid;
    own_acc   = acc_a || acc_b;
    other_st  = (state_q == OWN_B) ? OWN_A : OWN_B;
    cnt_inc   = {1'b0, cnt_q} + (CW + 1)'(1);

    unique case (state_q)
      IDLE: begin
        if (a_valid && b_valid) state_d = (last_q == SEL_A) ? OWN_B : OWN_A;
        else if (a_valid)       state_d = OWN_A;
        else if (b_valid)       state_d = OWN_B;
      end
      OWN_A, OWN_B: begin
        if (!own_valid) begin
          state_d = oth_valid ? other_st : IDLE;
        end else if (own_acc) begin
          if (cnt_inc == (CW + 1)'(MAX_BURST)) begin
            // Burst bound reached: hand over if the other side waits,
            // otherwise keep the grant and start a fresh burst.
            if (oth_valid) state_d = other_st;
            else           cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_q != IDLE) last_d = owner_sel(state_q);
    end

    if (state_d != IDLE) mux_sel_d = owner_sel(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= SEL_B;
      mux_sel_q <= SEL_A;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      mux_sel_q <= mux_sel_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (acc_a || acc_b) begin
      out_data_q  <= mux_y;
      out_src_q   <= mux_sel_q;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign mux_sel   = mux_sel_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

`ifdef MUX2_8_ARB_STATS_EN
  logic [15:0] stat_a_q, stat_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_a_q <= '0;
      stat_b_q <= '0;
    end else begin
      if (acc_a && (stat_a_q != '1)) stat_a_q <= stat_a_q + 16'd1;
      if (acc_b && (stat_b_q != '1)) stat_b_q <= stat_b_q + 16'd1;
    end
  end

  assign stat_a = stat_a_q;
  assign stat_b = stat_b_q;
`endif

endmodule

// File: tb/tb_mux2_8_arb.sv
// tb_mux2_8_arb: randomized and directed stimulus for mux2_8_arb, checked
// cycle by cycle against an integer-level reference model of the arbiter.
module tb_mux2_8_arb;

  localparam int MB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic       mux_sel, out_src, out_valid, out_ready;
  logic [7:0] out_data;
`ifdef MUX2_8_ARB_STATS_EN
  logic [15:0] stat_a, stat_b;
`endif

  mux2_8_arb #(.MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .mux_sel   (mux_sel),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
`ifdef MUX2_8_ARB_STATS_EN
    .stat_a    (stat_a),
    .stat_b    (stat_b),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0 = none, 1 = A, 2 = B; last = 1 (A) or 2 (B).
  int m_own, m_last, m_cnt, m_sel, m_ov, m_od, m_os, m_sa, m_sb;

  function automatic void model_reset();
    m_own = 0; m_last = 2; m_cnt = 0; m_sel = 0;
    m_ov = 0; m_od = 0; m_os = 0; m_sa = 0; m_sb = 0;
  endfunction

  function automatic void model_step(input int av, input int ad, input int bv,
                                     input int bd, input int ordy);
    int ra, rb, acca, accb, nxt, myv, othv;
    ra   = (m_own == 1) && (!m_ov || ordy);
    rb   = (m_own == 2) && (!m_ov || ordy);
    acca = av && ra;
    accb = bv && rb;
    if (acca || accb) begin
      m_od = acca ? ad : bd;
      m_os = accb;
      m_ov = 1;
      if (acca && m_sa < 65535) m_sa++;
      if (accb && m_sb < 65535) m_sb++;
    end else if (m_ov && ordy) begin
      m_ov = 0;
    end
    nxt = m_own;
    if (m_own == 0) begin
      if (av && bv)  nxt = (m_last == 1) ? 2 : 1;
      else if (av)   nxt = 1;
      else if (bv)   nxt = 2;
    end else begin
      myv  = (m_own == 1) ? av : bv;
      othv = (m_own == 1) ? bv : av;
      if (!myv) nxt = othv ? 3 - m_own : 0;
      else if (acca || accb) begin
        m_cnt++;
        if (m_cnt == MB) begin
          if (othv) nxt = 3 - m_own;
          else      m_cnt = 0;
        end
      end
    end
    if (nxt != m_own) begin
      if (m_own != 0) m_last = m_own;
      m_cnt = 0;
      m_own = nxt;
    end
    if (m_own == 1) m_sel = 0;
    else if (m_own == 2) m_sel = 1;
  endfunction

  task automatic compare_outputs(input int ordy);
    chk("out_valid", int'(out_valid), m_ov);
    chk("out_data",  int'(out_data),  m_od);
    chk("out_src",   int'(out_src),   m_os);
    chk("mux_sel",   int'(mux_sel),   m_sel);
    chk("a_ready",   int'(a_ready),   int'((m_own == 1) && (!m_ov || ordy)));
    chk("b_ready",   int'(b_ready),   int'((m_own == 2) && (!m_ov || ordy)));
`ifdef MUX2_8_ARB_STATS_EN
    chk("stat_a",    int'(stat_a),    m_sa);
    chk("stat_b",    int'(stat_b),    m_sb);
`endif
  endtask

  // One clock of stimulus: drive on the falling edge, check 1 time unit later,
  // then advance the model across the following rising edge.
  task automatic cycle(input int av, input int ad, input int bv, input int bd,
                       input int ordy);
    @(negedge clk);
    a_valid   = 1'(av);
    a_data    = 8'(ad);
    b_valid   = 1'(bv);
    b_data    = 8'(bd);
    out_ready = 1'(ordy);
    #1;
    compare_outputs(ordy);
    model_step(av, ad, bv, bd, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs(0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int pa, pb, pr;

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b0;
    model_reset();
    do_reset();

    // A alone with two beats, then idle drain.
    cycle(1, 8'h11, 0, 0, 1);
    cycle(1, 8'h11, 0, 0, 1);
    cycle(1, 8'h22, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // Both continuously valid: A first after reset, bursts of MB alternate.
    do_reset();
    for (int i = 0; i < 30; i++) cycle(1, 8'hA0 + i, 1, 8'hB0 + i, 1);

    // A alone for a long run: no release, bursts restart silently.
    do_reset();
    for (int i = 0; i < 14; i++) cycle(1, i, 0, 0, 1);

    // B owner stalled by backpressure, then released.
    do_reset();
    cycle(0, 0, 1, 8'h5A, 1);
    cycle(0, 0, 1, 8'h5A, 1);
    for (int i = 0; i < 5; i++) cycle(1, 8'h33, 1, 8'h5B, 0);
    for (int i = 0; i < 4; i++) cycle(1, 8'h33, 1, 8'h5C + i, 1);

    // Reset mid-burst with a beat held on the output.
    for (int i = 0; i < 3; i++) cycle(1, 8'h40 + i, 1, 8'h50 + i, 1);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 8'h60 + i, 1, 8'h70 + i, 1);

    // Randomized traffic with shifting valid/ready densities.
    for (int ph = 0; ph < 12; ph++) begin
      pa = $urandom_range(10, 100);
      pb = $urandom_range(10, 100);
      pr = $urandom_range(20, 100);
      for (int i = 0; i < 200; i++)
        cycle(int'($urandom_range(99, 0) < pa), int'($urandom_range(255, 0)),
              int'($urandom_range(99, 0) < pb), int'($urandom_range(255, 0)),
              int'($urandom_range(99, 0) < pr));
      if (ph == 5) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
